// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine: FSM states, mode
// encodings, the atan(2^-i) table at 32 fractional bits and angle scaling helpers.
package cordic_pkg;

    localparam int CORDIC_WL    = 21;
    localparam int CORDIC_FRAC  = 16;
    localparam int CORDIC_ITERS = 17;
    localparam int CORDIC_GUARD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cordic_state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // atan(2^-i) in radians, scaled by 2^32; beyond i=11 the value is 2^(32-i)
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'd3373259426, 32'd1991351318, 32'd1052175346, 32'd534100635,
        32'd268086748,  32'd134174063,  32'd67103403,   32'd33553749,
        32'd16777131,   32'd8388597,    32'd4194303,    32'd2097152,
        32'd1048576,    32'd524288,     32'd262144,     32'd131072,
        32'd65536,      32'd32768,      32'd16384,      32'd8192,
        32'd4096,       32'd2048,       32'd1024,       32'd512,
        32'd256,        32'd128,        32'd64,         32'd32,
        32'd16,         32'd8,          32'd4,          32'd2
    };

    localparam longint unsigned PI_OVER_2_Q32 = 64'd6746518852;

    // Round-to-nearest conversion from 32 fractional bits down to frac bits (frac <= 31)
    function automatic longint unsigned scale_angle(input longint unsigned q32, input int frac);
        longint unsigned half;
        half = 64'd1 << (31 - frac);
        return (q32 + half) >> (32 - frac);
    endfunction

    function automatic longint unsigned atan_q(input logic [4:0] idx, input int frac);
        return scale_angle({32'd0, ATAN_TABLE[idx]}, frac);
    endfunction

    localparam longint unsigned PI_OVER_2 = scale_angle(PI_OVER_2_Q32, CORDIC_FRAC);

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation: picks the rotation direction from the
// mode and applies the shift-add update to x/y and the angle step to z.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int XW = 23,
    parameter int ZW = 21
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic signed [ZW-1:0] z,
    input  logic signed [ZW-1:0] alpha,
    input  logic        [4:0]    shift,
    input  logic                 mode,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next,
    output logic signed [ZW-1:0] z_next
);

    logic                 d;
    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    always_comb begin
        // Rotation drives z toward 0; vectoring drives y toward 0
        d      = (mode == MODE_ROT) ? z[ZW-1] : ~y[XW-1];
        x_sh   = x >>> shift;
        y_sh   = y >>> shift;
        x_next = x;
        y_next = y;
        z_next = z;
        if (d) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + alpha;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - alpha;
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// Iterative multi-mode CORDIC engine, one micro-rotation per clock, valid/ready on
// both sides. Define CORDIC_QUADRANT_EXT_EN to pre-rotate operands by +-pi/2 at capture.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready_o is high only in IDLE; out_valid_o is high only in DONE and the result
// holds until out_ready_i is seen; valid never depends combinationally on ready.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH  = CORDIC_WL,
    parameter int FRAC_BITS    = CORDIC_FRAC,
    parameter int N_ITERATIONS = CORDIC_ITERS,
    parameter int GUARD_BITS   = CORDIC_GUARD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          mode_i,
    input  logic signed [WORD_LENGTH-1:0] x_i,
    input  logic signed [WORD_LENGTH-1:0] y_i,
    input  logic signed [WORD_LENGTH-1:0] z_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [WORD_LENGTH-1:0] x_o,
    output logic signed [WORD_LENGTH-1:0] y_o,
    output logic signed [WORD_LENGTH-1:0] z_o,
    output cordic_state_e                 state_o
);

    localparam int WL = WORD_LENGTH;
    localparam int IW = WORD_LENGTH + GUARD_BITS;
    localparam logic [4:0] LAST_ITER = 5'(N_ITERATIONS - 1);
    localparam logic signed [IW-1:0] SAT_MAX = IW'((64'sd1 <<< (WL - 1)) - 64'sd1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(64'sd1 <<< (WL - 1)));

    cordic_state_e        state_q, state_d;
    logic [4:0]           cnt_q;
    logic                 mode_q;
    logic signed [IW-1:0] x_q, y_q, x_n, y_n;
    logic signed [WL-1:0] z_q, z_n, alpha;
    logic signed [IW-1:0] x_ext, y_ext, cap_x, cap_y;
    logic signed [WL-1:0] cap_z;
    logic                 last_iter;

    function automatic logic signed [WL-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WL-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WL-1:0];
        else                  return v[WL-1:0];
    endfunction

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign state_o     = state_q;
    assign last_iter   = (cnt_q == LAST_ITER);
    assign alpha       = WL'(atan_q(cnt_q, FRAC_BITS));
    assign x_ext       = IW'(x_i);
    assign y_ext       = IW'(y_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = BUSY;
            BUSY:    if (last_iter)   state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CORDIC_QUADRANT_EXT_EN
    localparam logic signed [WL-1:0] PI_HALF = WL'(scale_angle(PI_OVER_2_Q32, FRAC_BITS));

    always_comb begin
        cap_x = x_ext;
        cap_y = y_ext;
        cap_z = z_i;
        if (mode_i == MODE_ROT) begin
            if (z_i > PI_HALF) begin
                cap_x = -y_ext;
                cap_y = x_ext;
                cap_z = z_i - PI_HALF;
            end else if (z_i < -PI_HALF) begin
                cap_x = y_ext;
                cap_y = -x_ext;
                cap_z = z_i + PI_HALF;
            end
        end else if (x_i[WL-1]) begin
            // Left half-plane: turn the vector into the right half-plane first
            if (!y_i[WL-1]) begin
                cap_x = y_ext;
                cap_y = -x_ext;
                cap_z = z_i + PI_HALF;
            end else begin
                cap_x = -y_ext;
                cap_y = x_ext;
                cap_z = z_i - PI_HALF;
            end
        end
    end
`else
    always_comb begin
        cap_x = x_ext;
        cap_y = y_ext;
        cap_z = z_i;
    end
`endif

    cordic_microrot #(
        .XW(IW),
        .ZW(WL)
    ) u_microrot (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .alpha  (alpha),
        .shift  (cnt_q),
        .mode   (mode_q),
        .x_next (x_n),
        .y_next (y_n),
        .z_next (z_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= MODE_ROT;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q    <= cap_x;
                        y_q    <= cap_y;
                        z_q    <= cap_z;
                        mode_q <= mode_i;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    x_q <= x_n;
                    y_q <= y_n;
                    z_q <= z_n;
                    if (last_iter) begin
                        cnt_q <= '0;
                        x_o   <= sat(x_n);
                        y_o   <= sat(y_n);
                        z_o   <= z_n;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine with hand-computed expected results.
module tb_cordic_engine;
    import cordic_pkg::*;

    localparam int WL     = 21;
    localparam int N_ITER = 17;
    localparam int TOL    = 17;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 mode_i;
    logic signed [WL-1:0] x_i, y_i, z_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic signed [WL-1:0] x_o, y_o, z_o;
    cordic_state_e        state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WL-1:0] exp_q[$];

    cordic_engine dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .x_o         (x_o),
        .y_o         (y_o),
        .z_o         (z_o),
        .state_o     (state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_tests++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic send_op(input logic m, input logic signed [WL-1:0] xv,
                           input logic signed [WL-1:0] yv, input logic signed [WL-1:0] zv);
        int guard;
        @(negedge clk);
        mode_i     = m;
        x_i        = xv;
        y_i        = yv;
        z_i        = zv;
        in_valid_i = 1'b1;
        guard      = 0;
        while (!in_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid_o) break;
        end
        check_val({tag, "_latency"}, lat, N_ITER, 0);
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        check_val({tag, "_in_ready_after"}, longint'(in_ready_o), 1, 0);
        check_val({tag, "_out_valid_after"}, longint'(out_valid_o), 0, 0);
    endtask

    task automatic check_outputs(input string tag);
        logic signed [WL-1:0] ex, ey, ez;
        ex = exp_q.pop_front();
        ey = exp_q.pop_front();
        ez = exp_q.pop_front();
        check_val({tag, "_x"}, longint'(x_o), longint'(ex), TOL);
        check_val({tag, "_y"}, longint'(y_o), longint'(ey), TOL);
        check_val({tag, "_z"}, longint'(z_o), longint'(ez), TOL);
    endtask

    task automatic run_op(input string tag, input logic m,
                          input logic signed [WL-1:0] xv, input logic signed [WL-1:0] yv,
                          input logic signed [WL-1:0] zv, input logic signed [WL-1:0] ex,
                          input logic signed [WL-1:0] ey, input logic signed [WL-1:0] ez);
        exp_q.push_back(ex);
        exp_q.push_back(ey);
        exp_q.push_back(ez);
        send_op(m, xv, yv, zv);
        wait_result(tag);
        check_outputs(tag);
        take_result(tag);
    endtask

    initial begin
        logic signed [WL-1:0] hx, hy, hz;

        // reset
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        mode_i      = MODE_ROT;
        x_i         = '0;
        y_i         = '0;
        z_i         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", longint'(in_ready_o), 1, 0);
        check_val("rst_out_valid", longint'(out_valid_o), 0, 0);
        check_val("rst_x", longint'(x_o), 0, 0);
        check_val("rst_state", longint'(state_o), longint'(IDLE), 0);
        @(negedge clk);
        rst = 1'b0;

        // rotation: gain, 30 degrees, -30 degrees
        run_op("rot_gain", MODE_ROT, 21'sd65536, 21'sd0, 21'sd0, 21'sd107922, 21'sd0, 21'sd0);
        run_op("rot_p30", MODE_ROT, 21'sd39797, 21'sd0, 21'sd34315, 21'sd56756, 21'sd32768, 21'sd0);
        run_op("rot_m30", MODE_ROT, 21'sd39797, 21'sd0, -21'sd34315, 21'sd56756, -21'sd32768, 21'sd0);

        // vectoring: first and fourth quadrant
        run_op("vec_q1", MODE_VEC, 21'sd65536, 21'sd65536, 21'sd0, 21'sd152628, 21'sd0, 21'sd51472);
        run_op("vec_q4", MODE_VEC, 21'sd65536, -21'sd65536, 21'sd0, 21'sd152628, 21'sd0, -21'sd51472);

        // backpressure: result must hold, in_valid ignored while DONE
        send_op(MODE_ROT, 21'sd39797, 21'sd0, 21'sd34315);
        wait_result("bp");
        check_val("bp_x_value", longint'(x_o), 56756, TOL);
        check_val("bp_y_value", longint'(y_o), 32768, TOL);
        hx = x_o;
        hy = y_o;
        hz = z_o;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid_i = c[0];
            mode_i     = MODE_VEC;
            x_i        = 21'($urandom_range(1000, 200000));
            y_i        = 21'($urandom_range(1000, 200000));
            z_i        = 21'($urandom_range(0, 50000));
            @(posedge clk);
            #1;
            check_val("bp_out_valid", longint'(out_valid_o), 1, 0);
            check_val("bp_in_ready", longint'(in_ready_o), 0, 0);
            check_val("bp_x_hold", longint'(x_o), longint'(hx), 0);
            check_val("bp_y_hold", longint'(y_o), longint'(hy), 0);
            check_val("bp_z_hold", longint'(z_o), longint'(hz), 0);
        end
        in_valid_i = 1'b0;
        take_result("bp");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("bp_no_ghost_op", longint'(state_o), longint'(IDLE), 0);
        end

        // reset in the middle of an operation
        send_op(MODE_ROT, 21'sd39797, 21'sd0, 21'sd34315);
        repeat (8) @(posedge clk);
        #2;
        check_val("mid_busy", longint'(state_o), longint'(BUSY), 0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready", longint'(in_ready_o), 1, 0);
        check_val("mid_rst_out_valid", longint'(out_valid_o), 0, 0);
        check_val("mid_rst_x", longint'(x_o), 0, 0);
        check_val("mid_rst_y", longint'(y_o), 0, 0);
        check_val("mid_rst_z", longint'(z_o), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", MODE_ROT, 21'sd39797, 21'sd0, 21'sd34315, 21'sd56756, 21'sd32768, 21'sd0);

        // saturation at both rails
        send_op(MODE_VEC, 21'sd524287, 21'sd524287, 21'sd0);
        wait_result("sat_pos");
        check_val("sat_pos_x", longint'(x_o), 1048575, 0);
        check_val("sat_pos_z", longint'(z_o), 51472, TOL);
        take_result("sat_pos");
        send_op(MODE_ROT, -21'sd700000, 21'sd0, 21'sd0);
        wait_result("sat_neg");
        check_val("sat_neg_x", longint'(x_o), -1048576, 0);
        check_val("sat_neg_z", longint'(z_o), 0, TOL);
        take_result("sat_neg");

`ifdef CORDIC_QUADRANT_EXT_EN
        run_op("ext_rot_pi", MODE_ROT, 21'sd65536, 21'sd0, 21'sd205887, -21'sd107922, 21'sd0, 21'sd0);
        run_op("ext_vec_q2", MODE_VEC, -21'sd65536, 21'sd65536, 21'sd0, 21'sd152628, 21'sd0, 21'sd154416);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
